// File: rtl/prbs_test_pkg.sv
// Shared definitions for the PRBS check slice: sequencer state encoding and pattern width.
package prbs_test_pkg;

    localparam int PRBS_PAT_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } prbs_state_t;

endpackage

// File: rtl/prbs_run_timer.sv
// Saturating RUN-cycle counter with budget compare; terminal fires on the last budgeted cycle.
module prbs_run_timer #(
    parameter int TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [TMO_W-1:0] limit,
    output logic [TMO_W-1:0] count,
    output logic             terminal
);

    logic [TMO_W-1:0] r_count;
    logic [TMO_W:0]   w_next_count;

    // One extra bit so a saturated count never wraps onto a small limit.
    assign w_next_count = {1'b0, r_count} + {{TMO_W{1'b0}}, 1'b1};
    assign terminal     = en && (limit != '0) && (w_next_count == {1'b0, limit});
    assign count        = r_count;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != '1)) begin
            r_count <= w_next_count[TMO_W-1:0];
        end
    end

endmodule

// File: rtl/prbs_test_ctrl.sv
// Sequencer for one PRBS check run: config latch, detector clear, generator seed/enable,
// and a sticky pass/timeout/abort result.
module prbs_test_ctrl
    import prbs_test_pkg::*;
#(
    parameter int TMO_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [PRBS_PAT_W-1:0] cfg_pattern,
    input  logic [7:0]            cfg_n_repeats,
    input  logic [7:0]            cfg_seed,
    input  logic [TMO_W-1:0]      cfg_timeout,
    input  logic                  det_found,
    output logic                  det_rst_n,
    output logic [PRBS_PAT_W-1:0] det_pattern,
    output logic [7:0]            det_n_repeats,
    output logic                  gen_load,
    output logic [7:0]            gen_seed,
    output logic                  gen_en,
    output logic                  busy,
    output logic                  done,
    output logic                  done_irq,
    output logic                  res_pass,
    output logic                  res_timeout,
    output logic                  res_abort,
    output logic [TMO_W-1:0]      run_cycles
);

    prbs_state_t      r_state, w_next;
    logic [TMO_W-1:0] r_timeout;
    logic             w_accept, w_set_pass, w_set_tmo, w_set_abort, w_terminal;

    prbs_run_timer #(.TMO_W(TMO_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (w_accept),
        .en       (r_state == ST_RUN),
        .limit    (r_timeout),
        .count    (run_cycles),
        .terminal (w_terminal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        w_set_pass  = 1'b0;
        w_set_tmo   = 1'b0;
        w_set_abort = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_next   = ST_ARM;
                    w_accept = 1'b1;
                end
            end
            ST_ARM: begin
                if (abort) begin
                    w_next      = ST_DONE;
                    w_set_abort = 1'b1;
                end else begin
                    w_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    w_next      = ST_DONE;
                    w_set_abort = 1'b1;
                end else if (det_found) begin
                    w_next     = ST_DONE;
                    w_set_pass = 1'b1;
                end else if (w_terminal) begin
                    w_next    = ST_DONE;
                    w_set_tmo = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_rst_n     <= 1'b0;
            det_pattern   <= '0;
            det_n_repeats <= '0;
            gen_seed      <= '0;
            r_timeout     <= '0;
            gen_load      <= 1'b0;
            gen_en        <= 1'b0;
            done_irq      <= 1'b0;
            res_pass      <= 1'b0;
            res_timeout   <= 1'b0;
            res_abort     <= 1'b0;
        end else begin
            if (w_accept) begin
                det_pattern   <= cfg_pattern;
                det_n_repeats <= cfg_n_repeats;
                gen_seed      <= cfg_seed;
                r_timeout     <= cfg_timeout;
                res_pass      <= 1'b0;
                res_timeout   <= 1'b0;
                res_abort     <= 1'b0;
            end
            if (w_set_pass)  res_pass    <= 1'b1;
            if (w_set_tmo)   res_timeout <= 1'b1;
            if (w_set_abort) res_abort   <= 1'b1;
            // Detector is held cleared in IDLE and ARM, released once the run begins.
            det_rst_n <= (w_next == ST_RUN) || (w_next == ST_DONE);
            gen_load  <= (w_next == ST_ARM);
            gen_en    <= (w_next == ST_RUN);
            done_irq  <= (w_next == ST_DONE) && (r_state != ST_DONE);
        end
    end

    assign busy = (r_state == ST_ARM) || (r_state == ST_RUN);
    assign done = (r_state == ST_DONE);

endmodule
